// File: rtl/vm_pkg.sv
// Shared constants and encodings for the VM thread scheduler.
// INACTIVE and KILL_REQ are the reserved PC values that mark a stopped thread and a pending kill.
package vm_pkg;

  localparam int VM_NUM_THREADS = 64;
  localparam int VM_PC_W        = 16;
  localparam int TID_W          = $clog2(VM_NUM_THREADS);

  localparam logic [VM_PC_W-1:0] INACTIVE = 16'hFFFF;
  localparam logic [VM_PC_W-1:0] KILL_REQ = 16'hFFFE;

  typedef enum logic {
    OP_SETVEC         = 1'b0,
    OP_UPDATE_CHANNEL = 1'b1
  } cmd_op_e;

  typedef enum logic [1:0] {
    CH_RESUME = 2'd0,
    CH_PAUSE  = 2'd1,
    CH_KILL   = 2'd2,
    CH_NONE   = 2'd3
  } chan_type_e;

endpackage

// File: rtl/vm_thread_table.sv
// Per-thread state storage.
// The main FSM owns pc/paused and reads/clears req_pc; the command port writes req_pc/req_paused.
module vm_thread_table
  import vm_pkg::*;
#(
  parameter int NUM_THREADS = VM_NUM_THREADS,
  parameter int PC_W        = VM_PC_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [$clog2(NUM_THREADS)-1:0] main_idx,
  output logic [PC_W-1:0]                pc_rd,
  output logic                           paused_rd,
  output logic [PC_W-1:0]                req_pc_rd,
  output logic                           req_paused_rd,
  input  logic                           pc_we,
  input  logic [PC_W-1:0]                pc_wdata,
  input  logic                           paused_we,
  input  logic                           paused_wdata,
  input  logic                           req_clr,
  input  logic [$clog2(NUM_THREADS)-1:0] cmd_idx,
  input  logic                           req_pc_we,
  input  logic [PC_W-1:0]                req_pc_wdata,
  input  logic                           req_paused_we,
  input  logic                           req_paused_wdata
);

  localparam logic [PC_W-1:0] PC_INACTIVE = PC_W'(INACTIVE);

  logic [PC_W-1:0]        pc_mem     [NUM_THREADS];
  logic [PC_W-1:0]        req_pc_mem [NUM_THREADS];
  logic [NUM_THREADS-1:0] paused_vec;
  logic [NUM_THREADS-1:0] req_paused_vec;

  assign pc_rd         = pc_mem[main_idx];
  assign paused_rd     = paused_vec[main_idx];
  assign req_pc_rd     = req_pc_mem[main_idx];
  assign req_paused_rd = req_paused_vec[main_idx];

  // NOTE: these arrays are flops, not RAM, so they are cleared in reset; that lets a frame start right after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_THREADS; i++) pc_mem[i] <= (i == 0) ? '0 : PC_INACTIVE;
    end else if (pc_we) begin
      pc_mem[main_idx] <= pc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) paused_vec <= '0;
    else if (paused_we) paused_vec[main_idx] <= paused_wdata;
  end

  // NOTE: both writes are non-blocking, so the later command write wins when it hits the index being cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_THREADS; i++) req_pc_mem[i] <= PC_INACTIVE;
    end else begin
      if (req_clr)   req_pc_mem[main_idx] <= PC_INACTIVE;
      if (req_pc_we) req_pc_mem[cmd_idx]  <= req_pc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) req_paused_vec <= '0;
    else if (req_paused_we) req_paused_vec[cmd_idx] <= req_paused_wdata;
  end

endmodule

// File: rtl/vm_thread_scheduler.sv
// Frame scheduler for the VM CPU's cooperative threads: commits pending requests, then runs each
// live thread until it yields. A separate command FSM services setVec/updateChannel at any time.
module vm_thread_scheduler
  import vm_pkg::*;
#(
  parameter int NUM_THREADS = VM_NUM_THREADS,
  parameter int PC_W        = VM_PC_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_start,
  output logic                           frame_done,
  output logic                           busy,
  output logic                           run_valid,
  output logic [$clog2(NUM_THREADS)-1:0] run_thread,
  output logic [PC_W-1:0]                run_pc,
  input  logic                           yield_valid,
  input  logic                           yield_kill,
  input  logic [PC_W-1:0]                yield_pc,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_op,
  input  logic [$clog2(NUM_THREADS)-1:0] cmd_first,
  input  logic [$clog2(NUM_THREADS)-1:0] cmd_last,
  input  logic [PC_W-1:0]                cmd_arg
);

  localparam int TW = $clog2(NUM_THREADS);
  localparam logic [TW-1:0]   LAST_IDX    = TW'(NUM_THREADS - 1);
  localparam logic [PC_W-1:0] PC_INACTIVE = PC_W'(INACTIVE);
  localparam logic [PC_W-1:0] PC_KILL     = PC_W'(KILL_REQ);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_APPLY = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_RANGE = 2'd1;
  localparam logic [1:0] C_ACK   = 2'd2;

  logic [2:0]      state;
  logic [TW-1:0]   idx;
  logic [1:0]      cstate;
  logic [TW-1:0]   cmd_t;
  logic [TW-1:0]   cmd_end;
  chan_type_e      cmd_type;

  logic [PC_W-1:0] pc_rd;
  logic            paused_rd;
  logic [PC_W-1:0] req_pc_rd;
  logic            req_paused_rd;
  logic            pc_we;
  logic [PC_W-1:0] pc_wdata;
  logic            req_clr;
  logic [TW-1:0]   cmd_idx;
  logic            req_pc_we;
  logic [PC_W-1:0] req_pc_wdata;
  logic            req_paused_we;
  logic            req_paused_wdata;
  logic            runnable;
  logic            is_setvec;

  assign runnable   = (pc_rd != PC_INACTIVE) && !paused_rd;
  assign is_setvec  = (cmd_op == OP_SETVEC);

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);
  assign run_valid  = (state == S_RUN);
  assign run_thread = run_valid ? idx : '0;
  assign run_pc     = run_valid ? pc_rd : '0;
  assign cmd_ready  = (cstate == C_ACK);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: if (frame_start) begin
          state <= S_APPLY;
          idx   <= '0;
        end
        S_APPLY: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) state <= S_SCAN;
        end
        S_SCAN: begin
          if (runnable) begin
            state <= S_RUN;
          end else begin
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) state <= S_DONE;
          end
        end
        S_RUN: if (yield_valid) begin
          idx   <= idx + 1'b1;
          state <= (idx == LAST_IDX) ? S_DONE : S_SCAN;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Main-side table writes: commit pending requests in APPLY, record the resume PC on yield.
  always_comb begin
    pc_we    = 1'b0;
    pc_wdata = pc_rd;
    req_clr  = 1'b0;
    if (state == S_APPLY && req_pc_rd != PC_INACTIVE) begin
      pc_we    = 1'b1;
      pc_wdata = (req_pc_rd == PC_KILL) ? PC_INACTIVE : req_pc_rd;
      req_clr  = 1'b1;
    end else if (state == S_RUN && yield_valid) begin
      pc_we    = 1'b1;
      pc_wdata = yield_kill ? PC_INACTIVE : yield_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cstate   <= C_IDLE;
      cmd_t    <= '0;
      cmd_end  <= '0;
      cmd_type <= CH_NONE;
    end else begin
      case (cstate)
        C_IDLE: if (cmd_valid) begin
          if (is_setvec || cmd_first > cmd_last) begin
            cstate <= C_ACK;
          end else begin
            cstate   <= C_RANGE;
            cmd_t    <= cmd_first;
            cmd_end  <= cmd_last;
            cmd_type <= chan_type_e'(cmd_arg[1:0]);
          end
        end
        C_RANGE: begin
          if (cmd_t == cmd_end) cstate <= C_ACK;
          else cmd_t <= cmd_t + 1'b1;
        end
        C_ACK:   cstate <= C_IDLE;
        default: cstate <= C_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_idx          = cmd_t;
    req_pc_we        = 1'b0;
    req_pc_wdata     = cmd_arg;
    req_paused_we    = 1'b0;
    req_paused_wdata = (cmd_type == CH_PAUSE);
    if (cstate == C_IDLE) begin
      cmd_idx   = cmd_first;
      req_pc_we = cmd_valid && is_setvec;
    end else if (cstate == C_RANGE) begin
      req_pc_we     = (cmd_type == CH_KILL);
      req_pc_wdata  = PC_KILL;
      req_paused_we = (cmd_type == CH_RESUME) || (cmd_type == CH_PAUSE);
    end
  end

  vm_thread_table #(
    .NUM_THREADS(NUM_THREADS),
    .PC_W       (PC_W)
  ) u_table (
    .clk             (clk),
    .reset           (reset),
    .main_idx        (idx),
    .pc_rd           (pc_rd),
    .paused_rd       (paused_rd),
    .req_pc_rd       (req_pc_rd),
    .req_paused_rd   (req_paused_rd),
    .pc_we           (pc_we),
    .pc_wdata        (pc_wdata),
    .paused_we       (state == S_APPLY),
    .paused_wdata    (req_paused_rd),
    .req_clr         (req_clr),
    .cmd_idx         (cmd_idx),
    .req_pc_we       (req_pc_we),
    .req_pc_wdata    (req_pc_wdata),
    .req_paused_we   (req_paused_we),
    .req_paused_wdata(req_paused_wdata)
  );

endmodule

// File: tb/tb_vm_thread_scheduler.sv
// Directed bench for vm_thread_scheduler. Inputs change and outputs are sampled on the falling edge.
// Cycle counts are measured from the first cycle after the triggering input was sampled.
module tb_vm_thread_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        frame_done;
  logic        busy;
  logic        run_valid;
  logic [5:0]  run_thread;
  logic [15:0] run_pc;
  logic        yield_valid;
  logic        yield_kill;
  logic [15:0] yield_pc;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [5:0]  cmd_first;
  logic [5:0]  cmd_last;
  logic [15:0] cmd_arg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vm_thread_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .busy       (busy),
    .run_valid  (run_valid),
    .run_thread (run_thread),
    .run_pc     (run_pc),
    .yield_valid(yield_valid),
    .yield_kill (yield_kill),
    .yield_pc   (yield_pc),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_first  (cmd_first),
    .cmd_last   (cmd_last),
    .cmd_arg    (cmd_arg)
  );

  task automatic start_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Counts cycles until run_valid or frame_done, bounded so a dead DUT cannot hang the bench.
  task automatic next_event(output int n);
    n = 0;
    while (!run_valid && !frame_done && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_yield(input logic [15:0] pc, input logic kill);
    yield_valid = 1'b1;
    yield_pc    = pc;
    yield_kill  = kill;
    @(negedge clk);
    yield_valid = 1'b0;
    yield_kill  = 1'b0;
  endtask

  task automatic send_cmd(input logic op, input logic [5:0] first, input logic [5:0] last,
                          input logic [15:0] arg, output int lat);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_first = first;
    cmd_last  = last;
    cmd_arg   = arg;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cmd_ready && lat < 200);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({frame_done, busy, run_valid, cmd_ready} !== 4'b0000 || run_thread !== 6'd0 || run_pc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: done/busy/valid/ready=%b thread=%0d pc=%h, expected 0000 0 0000",
               {frame_done, busy, run_valid, cmd_ready}, run_thread, run_pc);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_frame();
    int n;
    start_frame();
    next_event(n);
    checks++;
    if (n !== 65 || run_valid !== 1'b1 || run_thread !== 6'd0 || run_pc !== 16'h0000) begin
      errors++;
      $display("FAIL first_run: cycles=%0d valid=%b thread=%0d pc=%h, expected 65 1 0 0000", n, run_valid, run_thread, run_pc);
    end
    repeat (2) @(negedge clk);
    start_frame();
    @(negedge clk);
    checks++;
    if (run_valid !== 1'b1 || run_thread !== 6'd0 || run_pc !== 16'h0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_hold_frame_start: valid=%b thread=%0d pc=%h busy=%b, expected 1 0 0000 1", run_valid, run_thread, run_pc, busy);
    end
    do_yield(16'h0123, 1'b0);
    checks++;
    if (run_valid !== 1'b0) begin
      errors++;
      $display("FAIL yield_drop: valid=%b, expected 0", run_valid);
    end
    next_event(n);
    checks++;
    if (n !== 63 || frame_done !== 1'b1 || run_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_done: cycles=%0d done=%b valid=%b, expected 63 1 0", n, frame_done, run_valid);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done: done=%b busy=%b, expected 0 0", frame_done, busy);
    end
  endtask

  task automatic test_setvec();
    int n;
    int lat;
    start_frame();
    next_event(n);
    checks++;
    if (n !== 65 || run_thread !== 6'd0 || run_pc !== 16'h0123) begin
      errors++;
      $display("FAIL resume_pc: cycles=%0d thread=%0d pc=%h, expected 65 0 0123", n, run_thread, run_pc);
    end
    send_cmd(1'b0, 6'd5, 6'd0, 16'h0400, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL setvec_latency: got %0d, expected 1", lat);
    end
    @(negedge clk);
    do_yield(16'h0123, 1'b0);
    next_event(n);
    checks++;
    if (n !== 63 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL setvec_deferred: cycles=%0d done=%b, expected 63 1", n, frame_done);
    end
    @(negedge clk);
    start_frame();
    next_event(n);
    do_yield(16'h0123, 1'b0);
    next_event(n);
    checks++;
    if (n !== 5 || run_valid !== 1'b1 || run_thread !== 6'd5 || run_pc !== 16'h0400) begin
      errors++;
      $display("FAIL setvec_run: cycles=%0d valid=%b thread=%0d pc=%h, expected 5 1 5 0400", n, run_valid, run_thread, run_pc);
    end
    do_yield(16'h0400, 1'b0);
    next_event(n);
    checks++;
    if (n !== 58 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL setvec_done: cycles=%0d done=%b, expected 58 1", n, frame_done);
    end
    @(negedge clk);
  endtask

  task automatic test_pause_resume();
    int n;
    int lat;
    send_cmd(1'b1, 6'd5, 6'd5, 16'h0001, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL pause_latency: got %0d, expected 2", lat);
    end
    @(negedge clk);
    start_frame();
    next_event(n);
    do_yield(16'h0123, 1'b0);
    next_event(n);
    checks++;
    if (n !== 63 || frame_done !== 1'b1 || run_valid !== 1'b0) begin
      errors++;
      $display("FAIL paused_skip: cycles=%0d done=%b valid=%b, expected 63 1 0", n, frame_done, run_valid);
    end
    @(negedge clk);
    send_cmd(1'b1, 6'd5, 6'd5, 16'h0000, lat);
    @(negedge clk);
    start_frame();
    next_event(n);
    do_yield(16'h0123, 1'b0);
    next_event(n);
    checks++;
    if (n !== 5 || run_thread !== 6'd5 || run_pc !== 16'h0400) begin
      errors++;
      $display("FAIL resumed_run: cycles=%0d thread=%0d pc=%h, expected 5 5 0400", n, run_thread, run_pc);
    end
    do_yield(16'h0400, 1'b0);
    next_event(n);
    @(negedge clk);
  endtask

  task automatic test_kill();
    int n;
    int lat;
    start_frame();
    next_event(n);
    do_yield(16'h0123, 1'b1);
    next_event(n);
    do_yield(16'h0400, 1'b0);
    next_event(n);
    @(negedge clk);
    start_frame();
    next_event(n);
    checks++;
    if (n !== 70 || run_thread !== 6'd5 || run_pc !== 16'h0400) begin
      errors++;
      $display("FAIL killed_thread0: cycles=%0d thread=%0d pc=%h, expected 70 5 0400", n, run_thread, run_pc);
    end
    do_yield(16'h0400, 1'b0);
    next_event(n);
    @(negedge clk);
    send_cmd(1'b1, 6'd0, 6'd63, 16'h0002, lat);
    checks++;
    if (lat !== 65) begin
      errors++;
      $display("FAIL kill_all_latency: got %0d, expected 65", lat);
    end
    @(negedge clk);
    start_frame();
    next_event(n);
    checks++;
    if (n !== 128 || frame_done !== 1'b1 || run_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_frame: cycles=%0d done=%b valid=%b, expected 128 1 0", n, frame_done, run_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int lat;
    send_cmd(1'b0, 6'd7, 6'd0, 16'h0700, lat);
    @(negedge clk);
    start_frame();
    next_event(n);
    checks++;
    if (n !== 72 || run_thread !== 6'd7 || run_pc !== 16'h0700) begin
      errors++;
      $display("FAIL revived_run: cycles=%0d thread=%0d pc=%h, expected 72 7 0700", n, run_thread, run_pc);
    end
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    cmd_first = 6'd0;
    cmd_last  = 6'd63;
    cmd_arg   = 16'h0001;
    repeat (3) @(negedge clk);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({frame_done, busy, run_valid, cmd_ready} !== 4'b0000 || run_thread !== 6'd0 || run_pc !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_outputs: done/busy/valid/ready=%b thread=%0d pc=%h, expected 0000 0 0000",
               {frame_done, busy, run_valid, cmd_ready}, run_thread, run_pc);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_frame();
    next_event(n);
    checks++;
    if (n !== 65 || run_thread !== 6'd0 || run_pc !== 16'h0000) begin
      errors++;
      $display("FAIL post_reset_run: cycles=%0d thread=%0d pc=%h, expected 65 0 0000", n, run_thread, run_pc);
    end
    do_yield(16'h0000, 1'b0);
    next_event(n);
    checks++;
    if (n !== 63 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_only_t0: cycles=%0d done=%b, expected 63 1", n, frame_done);
    end
    @(negedge clk);
  endtask

  task automatic test_edge_cases();
    int n;
    int lat;
    send_cmd(1'b1, 6'd9, 6'd3, 16'h0002, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL reversed_range_latency: got %0d, expected 1", lat);
    end
    @(negedge clk);
    // A yield outside RUN must not touch thread 0.
    do_yield(16'h0555, 1'b1);
    checks++;
    if (busy !== 1'b0 || run_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_yield_state: busy=%b valid=%b, expected 0 0", busy, run_valid);
    end
    start_frame();
    next_event(n);
    checks++;
    if (n !== 65 || run_thread !== 6'd0 || run_pc !== 16'h0000) begin
      errors++;
      $display("FAIL stray_yield_ignored: cycles=%0d thread=%0d pc=%h, expected 65 0 0000", n, run_thread, run_pc);
    end
    do_yield(16'h0000, 1'b0);
    next_event(n);
    checks++;
    if (n !== 63 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL reversed_range_nochange: cycles=%0d done=%b, expected 63 1", n, frame_done);
    end
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b0;
    frame_start = 1'b0;
    yield_valid = 1'b0;
    yield_kill  = 1'b0;
    yield_pc    = '0;
    cmd_valid   = 1'b0;
    cmd_op      = 1'b0;
    cmd_first   = '0;
    cmd_last    = '0;
    cmd_arg     = '0;
    @(negedge clk);
    test_reset();
    test_first_frame();
    test_setvec();
    test_pause_resume();
    test_kill();
    test_reset_mid_frame();
    test_edge_cases();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
